// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver, bundled for port connection.
// master = the receiver itself, slave = line driver plus byte consumer.
interface uart_rx_if;
  logic       rx_uart;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  modport master (
    input  rx_uart,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy
  );

  modport slave (
    output rx_uart,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, and a valid/ack
// holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic     clk_50,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             sync1_q, sync2_q;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             load;
  logic             rxs;

  assign rxs = sync2_q;

  // Synchronizer resets high so an idle line is never mistaken for a start bit.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx_uart;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A load wins over a same-cycle ack; overrun only when the old byte was never taken.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q && !bus.rx_ack;
    end else if (valid_q && bus.rx_ack) begin
      valid_d = 1'b0;
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_overrun   = ovr_q;
  assign bus.rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a monitor pops expected bytes
// from a scoreboard queue whenever the receiver loads a new byte.
module tb_uart_rx;
  localparam int unsigned CPB = 16;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_50 = ~clk_50;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .bus    (u_if.master)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks   = 0;
  int unsigned errors   = 0;
  int unsigned cyc      = 0;
  int unsigned ferr_cnt = 0;
  int unsigned ovr_cnt  = 0;
  int unsigned exp_rise = 0;
  int unsigned ack_at   = 0;
  int unsigned ack_req  = 0;
  bit          auto_ack = 1'b0;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame = start, 8 data LSB-first, stop; caller enters on a falling clock edge.
  task automatic send(input logic [7:0] b, input logic stop, input logic ack_load);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (ack_load) ack_at = cyc + 1 + 153;
    for (int i = 0; i < 10; i++) begin
      u_if.rx_uart = fr[i];
      repeat (CPB) @(negedge clk_50);
    end
  endtask

  initial begin : monitor
    logic vprev;
    logic ack_e;
    exp_t e;
    vprev = 1'b0;
    forever begin
      @(posedge clk_50);
      ack_e = u_if.rx_ack;
      #1;
      if (u_if.rx_frame_err) ferr_cnt++;
      if (u_if.rx_overrun)   ovr_cnt++;
      if (u_if.rx_valid && (!vprev || ack_e || u_if.rx_overrun)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%02h expected none (cycle %0d)", u_if.rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(u_if.rx_data), 32'(e.data));
          chk("rx_overrun_on_load", 32'(u_if.rx_overrun), 32'(e.ovr));
        end
        if (!vprev && exp_rise != 0) chk("valid_rise_cycle", cyc, exp_rise);
      end
      vprev = u_if.rx_valid;
    end
  end

  initial begin : consumer
    int unsigned cd;
    int unsigned done;
    logic        vp;
    cd = 0;
    done = 0;
    vp = 1'b0;
    u_if.rx_ack = 1'b0;
    forever begin
      @(negedge clk_50);
      u_if.rx_ack = 1'b0;
      if (auto_ack && u_if.rx_valid && !vp) cd = 2;
      else if (cd != 0) begin
        cd--;
        if (cd == 0) u_if.rx_ack = 1'b1;
      end
      if (ack_req != done) begin
        done++;
        u_if.rx_ack = 1'b1;
      end
      if (ack_at != 0 && cyc == ack_at) u_if.rx_ack = 1'b1;
      vp = u_if.rx_valid;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] stream [4];
    stream[0] = 8'h80; stream[1] = 8'hC0; stream[2] = 8'hE0; stream[3] = 8'hF0;
    u_if.rx_uart = 1'b1;
    repeat (3) @(negedge clk_50);
    chk("reset_data",  32'(u_if.rx_data),      32'h00);
    chk("reset_valid", 32'(u_if.rx_valid),     32'h0);
    chk("reset_busy",  32'(u_if.rx_busy),      32'h0);
    chk("reset_ferr",  32'(u_if.rx_frame_err), 32'h0);
    chk("reset_ovr",   32'(u_if.rx_overrun),   32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50);

    // Clean byte with rise-time check and a manual one-cycle ack.
    exp_rise = cyc + 1 + 154;
    exp_q.push_back('{data: 8'h80, ovr: 1'b0});
    send(8'h80, 1'b1, 1'b0);
    exp_rise = 0;
    chk("clean_valid", 32'(u_if.rx_valid), 32'h1);
    chk("clean_busy",  32'(u_if.rx_busy),  32'h0);
    @(posedge clk_50); #1;
    ack_req++;
    @(posedge clk_50); #1;
    chk("ack_clears_valid", 32'(u_if.rx_valid), 32'h0);
    @(negedge clk_50);

    // Back-to-back stream with the consumer acking automatically.
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{data: stream[i], ovr: 1'b0});
    for (int i = 0; i < 4; i++) send(stream[i], 1'b1, 1'b0);
    repeat (10) @(negedge clk_50);
    chk("stream_ovr_cnt",  ovr_cnt,  0);
    chk("stream_ferr_cnt", ferr_cnt, 0);
    chk("stream_valid",    32'(u_if.rx_valid), 32'h0);

    // Start glitch: 5 cycles low is rejected at the half-bit sample.
    u_if.rx_uart = 1'b0;
    repeat (5) @(negedge clk_50);
    chk("glitch_busy_start", 32'(u_if.rx_busy), 32'h1);
    u_if.rx_uart = 1'b1;
    repeat (15) @(negedge clk_50);
    chk("glitch_busy_idle", 32'(u_if.rx_busy),  32'h0);
    chk("glitch_valid",     32'(u_if.rx_valid), 32'h0);
    chk("glitch_ferr_cnt",  ferr_cnt, 0);
    exp_q.push_back('{data: 8'h3C, ovr: 1'b0});
    send(8'h3C, 1'b1, 1'b0);
    repeat (5) @(negedge clk_50);

    // Framing error, line held low in BREAK, then recovery.
    send(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk_50);
    chk("break_ferr_cnt", ferr_cnt, 1);
    chk("break_busy",     32'(u_if.rx_busy),  32'h1);
    chk("break_valid",    32'(u_if.rx_valid), 32'h0);
    chk("break_data",     32'(u_if.rx_data),  32'h3C);
    u_if.rx_uart = 1'b1;
    repeat (5) @(negedge clk_50);
    chk("break_exit_busy", 32'(u_if.rx_busy), 32'h0);
    exp_q.push_back('{data: 8'hA5, ovr: 1'b0});
    send(8'hA5, 1'b1, 1'b0);
    repeat (10) @(negedge clk_50);
    chk("after_break_ferr_cnt", ferr_cnt, 1);

    // Overrun: second byte lands on an unconsumed first byte.
    auto_ack = 1'b0;
    exp_q.push_back('{data: 8'h12, ovr: 1'b0});
    exp_q.push_back('{data: 8'h34, ovr: 1'b1});
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    repeat (3) @(negedge clk_50);
    chk("ovr_cnt",   ovr_cnt, 1);
    chk("ovr_data",  32'(u_if.rx_data),  32'h34);
    chk("ovr_valid", 32'(u_if.rx_valid), 32'h1);
    @(posedge clk_50); #1;
    ack_req++;
    @(posedge clk_50); #1;
    chk("ovr_ack_clears", 32'(u_if.rx_valid), 32'h0);
    @(negedge clk_50);

    // Ack coinciding with the load cycle: no overrun, byte stays valid.
    exp_q.push_back('{data: 8'h12, ovr: 1'b0});
    exp_q.push_back('{data: 8'h34, ovr: 1'b0});
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b1);
    ack_at = 0;
    repeat (3) @(negedge clk_50);
    chk("coinc_ovr_cnt", ovr_cnt, 1);
    chk("coinc_valid",   32'(u_if.rx_valid), 32'h1);
    chk("coinc_data",    32'(u_if.rx_data),  32'h34);

    // Reset during data bit 3 of 0xFF.
    u_if.rx_uart = 1'b0;
    repeat (CPB) @(negedge clk_50);
    u_if.rx_uart = 1'b1;
    repeat (CPB * 3 + 8) @(negedge clk_50);
    chk("midframe_busy", 32'(u_if.rx_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_data",  32'(u_if.rx_data),  32'h00);
    chk("rst_async_valid", 32'(u_if.rx_valid), 32'h0);
    chk("rst_async_busy",  32'(u_if.rx_busy),  32'h0);
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    repeat (8 + CPB * 5) @(negedge clk_50);
    chk("post_rst_valid", 32'(u_if.rx_valid), 32'h0);
    chk("post_rst_busy",  32'(u_if.rx_busy),  32'h0);
    exp_q.push_back('{data: 8'h3C, ovr: 1'b0});
    send(8'h3C, 1'b1, 1'b0);
    repeat (3) @(negedge clk_50);
    chk("fresh_valid", 32'(u_if.rx_valid), 32'h1);
    chk("fresh_data",  32'(u_if.rx_data),  32'h3C);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    chk("total_ovr_cnt",  ovr_cnt,  1);
    chk("total_ferr_cnt", ferr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receiving end of the board's UART link. Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the `rx_uart` pin, which is clocked by `clk_50` and has no relation to the transmitter's clock. Each received byte is presented on a valid/ack holding register for the downstream consumer. Framing errors and overruns are flagged.

## Interface
- `CLKS_PER_BIT`, default 5208: `clk_50` cycles per bit. The default gives 9600 baud at 50 MHz. Legal values are 4 and above.
- `clk_50` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `rx_uart` input, 1 bit: serial line. Idles high. Asynchronous to `clk_50`.
- `rx_ack` input, 1 bit: consumer accepts `rx_data`. Sampled only while `rx_valid` is 1.
- `rx_data` output, 8 bits: last good byte received.
- `rx_valid` output, 1 bit: level signal meaning `rx_data` holds an unconsumed byte.
- `rx_frame_err` output, 1 bit: 1-cycle pulse when the stop bit is sampled low.
- `rx_overrun` output, 1 bit: 1-cycle pulse when a new byte overwrites an unconsumed one.
- `rx_busy` output, 1 bit: 1 whenever the FSM is not in IDLE.

## Operation
- **Reset values.**
  - `rx_data` = 0x00; `rx_valid`, `rx_frame_err`, `rx_overrun` and `rx_busy` = 0.
  - FSM = IDLE; counters = 0.
  - Both synchronizer flops reset to 1, so releasing reset while the line idles cannot be taken as a start bit.
- **Synchronizer.** Two flops on `rx_uart` produce the synced signal `rxs`. All decisions use `rxs` only.
- **Bit timer.**
  - Counter width is clog2(`CLKS_PER_BIT`).
  - HALF = floor(`CLKS_PER_BIT`/2).
  - The counter is cleared on every state entry and at every sample point.
- **FSM states and transitions:**
  - IDLE: when `rxs` = 0, go to START and clear the counter. Call this cycle t0.
  - START: at t0+HALF, sample `rxs`.
    - If 1, it was a glitch: go to IDLE. No flags.
    - If 0, go to DATA with bit index = 0.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rxs` into shift register bit 7 and shift right, so the byte ends LSB-first.
    - After the 8th sample (index 7), go to STOP.
    - The bit index is 3 bits and wraps 7→0 only on exit.
  - STOP: `CLKS_PER_BIT` cycles after the last data sample, sample `rxs`.
    - If 1: load `rx_data` from the shift register, set `rx_valid`, go to IDLE.
    - If 0: pulse `rx_frame_err`, leave `rx_data` and `rx_valid` unchanged, go to BREAK.
  - BREAK: wait until `rxs` = 1, then go to IDLE. This prevents a held-low line from retriggering continuously.
- **Handshake.**
  - `rx_valid` is set on a good stop bit.
  - `rx_valid` is cleared in the cycle after `rx_ack` = 1 while `rx_valid` = 1.
  - `rx_ack` is ignored while `rx_valid` = 0.
- **Overrun.** A good byte arrives while `rx_valid` = 1 and `rx_ack` = 0 in that cycle. Then:
  - `rx_data` is overwritten and `rx_valid` stays 1.
  - `rx_overrun` pulses for 1 cycle.
- **Simultaneous load and ack.** If a good stop bit coincides with `rx_ack` = 1, the new byte is loaded, `rx_valid` stays 1, and there is no overrun.
- **Reset mid-frame.** All state is abandoned immediately and no partial byte is ever presented.

## Timing
- **Pin to `rxs`:** 2 cycles.
- **Sample points, relative to t0:**
  - start bit: t0+HALF
  - data bit n (n = 0..7): t0+HALF+(n+1)·`CLKS_PER_BIT`
  - stop bit: t0+HALF+9·`CLKS_PER_BIT`
- **Outputs after the stop sample:** `rx_valid`, `rx_data`, `rx_frame_err` and `rx_overrun` change in the cycle after the stop sample. With the default parameter this is t0+HALF+9·`CLKS_PER_BIT`+1 = t0+49477.
- **`rx_busy`:** rises at t0+1 and falls in the same cycle that the FSM returns to IDLE.
- **Next start bit:** detectable from the first cycle in IDLE. Back-to-back frames with a single stop bit are supported.
- **Tolerance:** mid-bit sampling tolerates ±4% total baud mismatch.

## Test plan
Benches use `CLKS_PER_BIT` = 16 (HALF = 8). The serial line is driven bit-accurately at 16 cycles per bit.
- **Clean byte.** One clean frame of 0x80. Expect `rx_data` = 0x80, `rx_valid` rising at t0+153, no flags. Then `rx_ack` for 1 cycle; expect `rx_valid` = 0 on the next cycle.
- **Back-to-back stream.** Frames 0x80, 0xC0, 0xE0, 0xF0 back-to-back, with the consumer acking 2 cycles after each `rx_valid`. Expect four bytes in order and no `rx_overrun` or `rx_frame_err`.
- **Start glitch.** `rx_uart` low for 5 cycles, then high. Expect return to IDLE at t0+8, no `rx_valid`, no flags. A following 0x3C frame is received correctly.
- **Framing error and break.** 0x55 sent with stop bit = 0, and the line held low a further 40 cycles. Expect a single `rx_frame_err` pulse, `rx_data`/`rx_valid` unchanged, and the FSM staying in BREAK. After the line goes high, a 0xA5 frame is received correctly.
- **Overrun.** Frames 0x12 then 0x34 with no ack. Expect one `rx_overrun` pulse, `rx_data` = 0x34, `rx_valid` = 1. Repeat with `rx_ack` asserted exactly on the 0x34 load cycle; expect no `rx_overrun`.
- **Reset mid-frame.** `rst_n` low during data bit 3 of 0xFF. Expect all outputs at reset values asynchronously. Release with the line high and finish the old frame's remaining bits; expect no `rx_valid` for the corrupted byte. A fresh 0x3C frame is then received.
